// File: rtl/cordic_phase_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cordic_phase_multi - pipelined CORDIC vectoring atan2/magnitude, multi-channel
// Revision: 1.0
// -----------------------------------------------------------------------------
module cordic_phase_multi #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 14,
  parameter int CH_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_i,
  input  logic signed [DATA_WIDTH-1:0]  in_q,
  input  logic        [CH_WIDTH-1:0]    in_ch,
  input  logic                          in_diff,
  output logic                          out_valid,
  output logic signed [PHASE_WIDTH-1:0] out_phase,
  output logic        [DATA_WIDTH+1:0]  out_mag,
  output logic        [CH_WIDTH-1:0]    out_ch,
  output logic                          out_zero
);

  localparam int XW  = DATA_WIDTH + 2;
  localparam int NCH = 1 << CH_WIDTH;
  localparam logic [PHASE_WIDTH-1:0] PI_CODE = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

  // Elaboration-time arctangent table: atan(2^-k) scaled so that pi = 2^(PHASE_WIDTH-1).
  function automatic logic [ITERATIONS*PHASE_WIDTH-1:0] atan_table();
    logic [ITERATIONS*PHASE_WIDTH-1:0] tab;
    real pi, t, term, acc, scale;
    pi    = 3.14159265358979323846;
    scale = real'(2 ** (PHASE_WIDTH - 1));
    tab   = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (k == 0) begin
        acc = pi / 4.0;
      end else begin
        t    = 1.0 / real'(2 ** k);
        acc  = 0.0;
        term = t;
        for (int n = 0; n < 40; n++) begin
          acc  = acc + (((n % 2) == 0) ? 1.0 : -1.0) * term / real'(2 * n + 1);
          term = term * t * t;
        end
      end
      tab[k*PHASE_WIDTH +: PHASE_WIDTH] = PHASE_WIDTH'(int'(acc / pi * scale));
    end
    return tab;
  endfunction

  localparam logic [ITERATIONS*PHASE_WIDTH-1:0] ATAN_TAB = atan_table();

  logic                         in_vld_r, diff_r, zero_r;
  logic signed [DATA_WIDTH-1:0] i_r, q_r;
  logic        [CH_WIDTH-1:0]   ch_r;

  always_ff @(posedge clk) begin
    if (reset) in_vld_r <= 1'b0;
    else       in_vld_r <= in_valid;
    i_r    <= in_i;
    q_r    <= in_q;
    ch_r   <= in_ch;
    diff_r <= in_diff;
    zero_r <= (in_i == '0) && (in_q == '0);
  end

  logic                         vld    [0:ITERATIONS];
  logic        [CH_WIDTH-1:0]   ch_p   [0:ITERATIONS];
  logic                         diff_p [0:ITERATIONS];
  logic                         zero_p [0:ITERATIONS];
  logic signed [XW-1:0]         x_p    [0:ITERATIONS];
  logic signed [XW-1:0]         y_p    [0:ITERATIONS];
  logic        [PHASE_WIDTH-1:0] z_p   [0:ITERATIONS];

  logic signed [XW-1:0] i_ext, q_ext;
  assign i_ext = {{2{i_r[DATA_WIDTH-1]}}, i_r};
  assign q_ext = {{2{q_r[DATA_WIDTH-1]}}, q_r};

  // Fold the left half-plane onto the right so the micro-rotations only span +-pi/2.
  always_ff @(posedge clk) begin
    if (reset) vld[0] <= 1'b0;
    else       vld[0] <= in_vld_r;
    ch_p[0]   <= ch_r;
    diff_p[0] <= diff_r;
    zero_p[0] <= zero_r;
    if (i_r[DATA_WIDTH-1]) begin
      x_p[0] <= -i_ext;
      y_p[0] <= -q_ext;
      z_p[0] <= PI_CODE;
    end else begin
      x_p[0] <= i_ext;
      y_p[0] <= q_ext;
      z_p[0] <= '0;
    end
  end

  for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
    localparam logic [PHASE_WIDTH-1:0] ATAN_K = ATAN_TAB[k*PHASE_WIDTH +: PHASE_WIDTH];
    always_ff @(posedge clk) begin
      if (reset) vld[k+1] <= 1'b0;
      else       vld[k+1] <= vld[k];
      ch_p[k+1]   <= ch_p[k];
      diff_p[k+1] <= diff_p[k];
      zero_p[k+1] <= zero_p[k];
      if (!y_p[k][XW-1]) begin
        x_p[k+1] <= x_p[k] + (y_p[k] >>> k);
        y_p[k+1] <= y_p[k] - (x_p[k] >>> k);
        z_p[k+1] <= z_p[k] + ATAN_K;
      end else begin
        x_p[k+1] <= x_p[k] - (y_p[k] >>> k);
        y_p[k+1] <= y_p[k] + (x_p[k] >>> k);
        z_p[k+1] <= z_p[k] - ATAN_K;
      end
    end
  end

  logic [NCH-1:0]                  primed;
  logic [NCH-1:0][PHASE_WIDTH-1:0] last_ph;
  logic [PHASE_WIDTH-1:0]          z_fin;
  logic [CH_WIDTH-1:0]             ch_fin;

  assign z_fin  = z_p[ITERATIONS];
  assign ch_fin = ch_p[ITERATIONS];

  // History is read and written in this one stage, so back-to-back samples see each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_phase <= '0;
      out_mag   <= '0;
      out_ch    <= '0;
      out_zero  <= 1'b0;
      primed    <= '0;
      last_ph   <= '0;
    end else begin
      out_valid <= vld[ITERATIONS];
      if (vld[ITERATIONS]) begin
        out_ch   <= ch_fin;
        out_zero <= zero_p[ITERATIONS];
        if (zero_p[ITERATIONS]) begin
          out_phase <= '0;
          out_mag   <= '0;
        end else begin
          out_mag <= x_p[ITERATIONS];
          if (!diff_p[ITERATIONS])  out_phase <= z_fin;
          else if (primed[ch_fin])  out_phase <= z_fin - last_ph[ch_fin];
          else                      out_phase <= '0;
          last_ph[ch_fin] <= z_fin;
          primed[ch_fin]  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cordic_phase_multi - randomized bench with an ideal atan2/magnitude model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_cordic_phase_multi;

  localparam int  DW  = 16;
  localparam int  PW  = 16;
  localparam int  IT  = 14;
  localparam int  CW  = 2;
  localparam int  NCH = 1 << CW;
  localparam int  LAT = IT + 3;
  localparam real PI  = 3.14159265358979323846;
  localparam real TOL = real'(IT / 2 + 2);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_i = '0;
  logic signed [DW-1:0] in_q = '0;
  logic        [CW-1:0] in_ch = '0;
  logic                 in_diff = 1'b0;
  logic                 out_valid;
  logic signed [PW-1:0] out_phase;
  logic        [DW+1:0] out_mag;
  logic        [CW-1:0] out_ch;
  logic                 out_zero;

  cordic_phase_multi #(
    .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ITERATIONS(IT), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .in_ch(in_ch), .in_diff(in_diff), .out_valid(out_valid), .out_phase(out_phase),
    .out_mag(out_mag), .out_ch(out_ch), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  due;
    int  ch;
    bit  zero;
    real ph;
    real ph_tol;
    real mag;
    real mag_tol;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  real  last_ph [NCH];
  bit   primed  [NCH];
  real  kgain;

  function automatic real wrapd(input real d);
    real r;
    r = d;
    while (r > 32768.0)   r = r - 65536.0;
    while (r <= -32768.0) r = r + 65536.0;
    return r;
  endfunction

  task automatic check_near(input string name, input real act, input real expv,
                            input real tol, input bit circ);
    real d;
    checks++;
    d = act - expv;
    if (circ) d = wrapd(d);
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0.1f expected %0.2f +/- %0.1f", name, cyc, act, expv, tol);
    end
  endtask

  task automatic check_eq(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Reference: ideal atan2 and scaled magnitude, plus per-channel phase history.
  task automatic send(input int i, input int q, input int ch, input bit diff, input bit lit,
                      input real lph, input real ltol, input real lmag, input real lmtol);
    exp_t e;
    real  ph;
    @(negedge clk);
    in_valid = 1'b1;
    in_i     = DW'(i);
    in_q     = DW'(q);
    in_ch    = CW'(ch);
    in_diff  = diff;
    e.due  = cyc + LAT;
    e.ch   = ch;
    e.zero = (i == 0) && (q == 0);
    ph     = $atan2(real'(q), real'(i)) / PI * 32768.0;
    if (e.zero) begin
      e.ph = 0.0; e.ph_tol = 0.0; e.mag = 0.0; e.mag_tol = 0.0;
    end else begin
      e.mag     = kgain * $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
      e.mag_tol = real'(IT + 4);
      if (!diff) begin
        e.ph = ph; e.ph_tol = TOL;
      end else if (!primed[ch]) begin
        e.ph = 0.0; e.ph_tol = 0.0;
      end else begin
        e.ph = wrapd(ph - last_ph[ch]); e.ph_tol = 2.0 * TOL;
      end
      last_ph[ch] = ph;
      primed[ch]  = 1'b1;
    end
    if (lit) begin
      e.ph = lph; e.ph_tol = ltol;
      if (lmag >= 0.0) begin e.mag = lmag; e.mag_tol = lmtol; end
    end
    expq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_i     = DW'($urandom);
    in_q     = DW'($urandom);
    in_ch    = CW'($urandom);
    in_diff  = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    expq.delete();
    for (int c = 0; c < NCH; c++) primed[c] = 1'b0;
    @(posedge clk);
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_phase", out_phase, 0);
    check_eq("rst_mag",   out_mag,   0);
    check_eq("rst_ch",    out_ch,    0);
    check_eq("rst_zero",  out_zero,  0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_iq(output int i, output int q);
    longint r2;
    r2 = 0;
    i  = 0;
    q  = 0;
    for (int t = 0; t < 100 && r2 < 64'd268435456; t++) begin
      i  = int'($urandom_range(0, 65535)) - 32768;
      q  = int'($urandom_range(0, 65535)) - 32768;
      r2 = longint'(i) * i + longint'(q) * q;
    end
  endtask

  // Compare process: one check every cycle, against the front of the expectation queue.
  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check_eq("valid", out_valid, 1);
        check_eq("ch", out_ch, e.ch);
        check_eq("zero", out_zero, e.zero);
        check_near("phase", real'(out_phase), e.ph, e.ph_tol, 1'b1);
        check_near("mag", real'(out_mag), e.mag, e.mag_tol, 1'b0);
      end else begin
        check_eq("no_valid", out_valid, 0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int i, q, ch;
    real th;
    kgain = 1.0;
    for (int k = 0; k < IT; k++) kgain = kgain * $sqrt(1.0 + $pow(0.25, real'(k)));
    for (int c = 0; c < NCH; c++) begin primed[c] = 1'b0; last_ph[c] = 0.0; end

    repeat (3) @(negedge clk);
    check_eq("init_valid", out_valid, 0);
    check_eq("init_phase", out_phase, 0);
    check_eq("init_mag", out_mag, 0);
    reset = 1'b0;

    // Quadrant points and magnitude, absolute mode
    send(16384, 0, 0, 0, 1, 0.0, 4.0, 26981.0, 4.0);
    send(0, 16384, 0, 0, 1, 16384.0, 4.0, -1.0, 0.0);
    send(-16384, 0, 0, 0, 1, -32768.0, 4.0, -1.0, 0.0);
    send(-16384, 16384, 0, 0, 1, 24576.0, 4.0, -1.0, 0.0);
    idle(); idle(); idle();
    send(0, -16384, 0, 0, 1, -16384.0, 4.0, -1.0, 0.0);
    send(-32768, -32768, 3, 0, 1, -24576.0, 4.0, 76311.0, 8.0);

    // Differential wrap on ch1, then a zero sample that must not disturb history
    send(-16384, 16384, 1, 1, 1, 0.0, 0.0, -1.0, 0.0);
    send(-16384, -16384, 1, 1, 1, 16384.0, 4.0, -1.0, 0.0);
    send(0, 0, 1, 1, 1, 0.0, 0.0, 0.0, 0.0);
    send(16384, 0, 1, 1, 1, 24576.0, 4.0, -1.0, 0.0);

    // Interleaved rotating phasors, ch0 at +1024 and ch2 at -2048 LSB/sample
    for (int n = 0; n < 64; n++) begin
      ch = (n % 2 == 0) ? 0 : 2;
      th = ((ch == 0) ? real'((n / 2) * 1024) : real'(-(n / 2) * 2048)) * PI / 32768.0;
      send(int'(16384.0 * $cos(th)), int'(16384.0 * $sin(th)), ch, 1, 0, 0.0, 0.0, -1.0, 0.0);
    end

    // Reset with samples in flight, then every channel must restart unprimed
    for (int n = 0; n < 10; n++) begin
      rand_iq(i, q);
      send(i, q, n % NCH, 1'($urandom), 0, 0.0, 0.0, -1.0, 0.0);
    end
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      rand_iq(i, q);
      send(i, q, c, 1, 1, 0.0, 0.0, -1.0, 0.0);
    end

    // Randomized traffic with gaps and occasional zero samples in diff mode
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else if ($urandom_range(0, 19) == 0) begin
        send(0, 0, int'($urandom_range(0, NCH - 1)), 1, 0, 0.0, 0.0, -1.0, 0.0);
      end else begin
        rand_iq(i, q);
        send(i, q, int'($urandom_range(0, NCH - 1)), 1'($urandom), 0, 0.0, 0.0, -1.0, 0.0);
      end
    end

    repeat (LAT + 5) idle();
    check_eq("drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
